dec_lut_arbiter: RTL and testbench
==================================

DEC_LUT_ARBITER -- requirements
Module: dec_lut_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter W_BITS, default 34: decoder input width.
REQ-003 Parameter N_BITS, default 21: decoder result width.
REQ-004 Parameter SETTLE_CYC, default 1: cycles waited after dec_found before dec_n is sampled, 1..15.
REQ-005 Parameter TIMEOUT, default 1024: maximum WAIT cycles when the timeout is compiled in.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 req  in  NREQ  per-requester job request, level.
REQ-009 req_w  in  NREQ*W_BITS  per-requester W operand; slice i belongs to requester i.
REQ-010 gnt  out  NREQ  one-hot grant pulse, one cycle.
REQ-011 rsp_valid  out  1  result strobe, one cycle.
REQ-012 rsp_id  out  clog2(NREQ)  requester index of the current result.
REQ-013 rsp_n  out  N_BITS  decoded N.
REQ-014 rsp_err  out  1  job ended by timeout.
REQ-015 dec_rst_n  out  1  active-low per-job clear to the shared decoder.
REQ-016 dec_w  out  W_BITS  W operand to the decoder, registered.
REQ-017 dec_found  in  1  decoder done flag, level.
REQ-018 dec_n  in  N_BITS  decoder result.

Function
REQ-019 The FSM shall have exactly five states: IDLE, LOAD, WAIT, SETTLE, RESP.
REQ-020 In IDLE with any req bit high at edge t, the FSM shall enter LOAD at t+1. gnt shall equal the one-hot winner during the LOAD cycle. dec_w shall take the winner's req_w slice at the same edge.
REQ-021 Arbitration shall be round-robin. Priority starts at (last granted index + 1) mod NREQ; after reset it starts at index 0.
REQ-022 In LOAD, dec_rst_n shall be 0 for exactly one cycle. In all other states it shall be 1. LOAD always transitions to WAIT.
REQ-023 dec_w shall hold the captured operand from LOAD until the next LOAD, independent of req_w changes.
REQ-024 In WAIT, dec_found sampled at 1 shall move the FSM to SETTLE and clear the settle counter.
REQ-025 SETTLE shall last exactly SETTLE_CYC cycles. On the last one, rsp_n shall register dec_n and the FSM shall move to RESP.
REQ-026 RESP shall last one cycle: rsp_valid=1 and rsp_id=granted index; the FSM then returns to IDLE.
REQ-027 rsp_n, rsp_id and rsp_err shall hold their values until the next RESP.
REQ-028 req shall be sampled only in IDLE. A request still high after its job completes competes again under the rotated priority.
REQ-029 Minimum job latency is 4+SETTLE_CYC cycles from the accepting IDLE edge to rsp_valid, when dec_found is already high in the first WAIT cycle.
REQ-030 req bits going low while a job is in flight shall not abort the job.

Reset
REQ-031 rst high at an edge shall force IDLE from any state, including mid-WAIT or mid-SETTLE, with no response generated.
REQ-032 Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_n=0, rsp_err=0, dec_rst_n=0, dec_w=0, priority pointer=0.
REQ-033 dec_rst_n shall return to 1 in the first cycle after rst deasserts.

Configuration
REQ-034 With macro DEC_ARB_TIMEOUT_EN defined, a WAIT counter shall run. If dec_found is not seen for TIMEOUT cycles, the FSM shall go directly to RESP with rsp_err=1 and rsp_n=0.
REQ-035 Without DEC_ARB_TIMEOUT_EN, no counter is built, WAIT persists until dec_found, and rsp_err shall be constant 0.

Verification
REQ-036 Reset mid-job: assert rst while in WAIT -> next cycle state IDLE, all outputs at REQ-032 values, no rsp_valid.
REQ-037 Single job: req=4'b0010, slice1=34'd12345, decoder model returns found after 7 cycles with N=21'd1048575 -> gnt=4'b0010 once, dec_w=12345, rsp_valid with rsp_id=1, rsp_n=1048575, rsp_err=0.
REQ-038 All requesters held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3, one rsp_valid per job, in order.
REQ-039 Immediate found with SETTLE_CYC=1 -> rsp_valid exactly 5 cycles after the accepting edge.
REQ-040 With DEC_ARB_TIMEOUT_EN and TIMEOUT=16, dec_found held 0 -> rsp_valid 16 cycles after WAIT entry, rsp_err=1, rsp_n=0; the next job completes normally.
REQ-041 req_w slice changed to 0 during WAIT -> dec_w unchanged and result unaffected.

Source files
------------

// File: rtl/dec_lut_arbiter.sv
// Round-robin arbiter that shares one decoder among NREQ requesters and runs each job through LOAD/WAIT/SETTLE/RESP.
// Optional WAIT timeout is enabled with `define DEC_ARB_TIMEOUT_EN.
module dec_lut_arbiter #(
  parameter int NREQ       = 4,
  parameter int W_BITS     = 34,
  parameter int N_BITS     = 21,
  parameter int SETTLE_CYC = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W_BITS-1:0]    req_w,
  output logic [NREQ-1:0]           gnt,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N_BITS-1:0]         rsp_n,
  output logic                      rsp_err,
  output logic                      dec_rst_n,
  output logic [W_BITS-1:0]         dec_w,
  input  logic                      dec_found,
  input  logic [N_BITS-1:0]         dec_n
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SETTLE, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   job_id;
  logic [IDW-1:0]   win_idx;
  logic             any_req;
  logic [W_BITS-1:0] win_w;
  logic [3:0]       scnt;

`ifdef DEC_ARB_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wcnt;
  logic           err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Winner is the requester at the smallest rotated distance from ptr.
  always_comb begin : arb
    int d;
    int best;
    d       = 0;
    best    = NREQ;
    win_idx = ptr;
    win_w   = '0;
    any_req = |req;
    for (int i = 0; i < NREQ; i++) begin
      d = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
      if (req[i] && d < best) begin
        best    = d;
        win_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_w = req_w[i*W_BITS +: W_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_n     <= '0;
      dec_rst_n <= 1'b0;
      dec_w     <= '0;
      ptr       <= '0;
      job_id    <= '0;
      scnt      <= '0;
`ifdef DEC_ARB_TIMEOUT_EN
      wcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      dec_rst_n <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= LOAD;
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            dec_w     <= win_w;
            dec_rst_n <= 1'b0;
            job_id    <= win_idx;
            ptr       <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
          end
        end
        LOAD: begin
          state <= WAIT;
`ifdef DEC_ARB_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (dec_found) begin
            state <= SETTLE;
            scnt  <= '0;
          end
`ifdef DEC_ARB_TIMEOUT_EN
          else if (wcnt == WCW'(TIMEOUT-1)) begin
            // Give up on the decoder: report an errored, zero result.
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_n     <= '0;
            err_q     <= 1'b1;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
`endif
        end
        SETTLE: begin
          if (scnt == 4'(SETTLE_CYC-1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_n     <= dec_n;
`ifdef DEC_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_lut_arbiter.sv
// Scoreboard bench for dec_lut_arbiter with a simple delayed-found decoder model.
module tb_dec_lut_arbiter;

  localparam int NREQ = 4;
  localparam int WB   = 34;
  localparam int NB   = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*WB-1:0] req_w = '0;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [NB-1:0]     rsp_n;
  logic              rsp_err;
  logic              dec_rst_n;
  logic [WB-1:0]     dec_w;
  logic              dec_found;
  logic [NB-1:0]     dec_n;

  dec_lut_arbiter #(
    .NREQ(NREQ), .W_BITS(WB), .N_BITS(NB), .SETTLE_CYC(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_w(req_w), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_n(rsp_n), .rsp_err(rsp_err),
    .dec_rst_n(dec_rst_n), .dec_w(dec_w), .dec_found(dec_found), .dec_n(dec_n)
  );

  always #5 clk = ~clk;

  // Decoder model: found rises found_delay cycles after its clear is released.
  int          found_delay = 0;
  logic [NB-1:0] dec_val = '0;
  int          dcnt = 0;
  always @(posedge clk) begin
    if (!dec_rst_n) dcnt <= 0;
    else if (dcnt < 100000) dcnt <= dcnt + 1;
  end
  assign dec_found = dec_rst_n && (dcnt >= found_delay);
  assign dec_n     = dec_val;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NREQ-1:0] g; logic [WB-1:0] w; } gexp_t;
  typedef struct { logic [1:0] id; logic [NB-1:0] n; logic err; } rexp_t;
  gexp_t gnt_q[$];
  rexp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int gnt_seen = 0;
  int rsp_seen = 0;
  int t_gnt = 0;
  int last_lat = 0;
  int last_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    gexp_t ge;
    rexp_t re;
    if (!rst && gnt != '0) begin
      gnt_seen++;
      t_gnt = cyc;
      if (gnt_q.size() == 0) check("gnt_unexpected", 64'(gnt), 64'd0);
      else begin
        ge = gnt_q.pop_front();
        check("gnt", 64'(gnt), 64'(ge.g));
        check("dec_w", 64'(dec_w), 64'(ge.w));
      end
    end
    if (rsp_valid) begin
      rsp_seen++;
      // IDLE accept cycle through RESP cycle, inclusive.
      last_lat  = cyc - t_gnt + 2;
      last_wait = cyc - (t_gnt + 1);
      if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        re = rsp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(re.id));
        check("rsp_n", 64'(rsp_n), 64'(re.n));
        check("rsp_err", 64'(rsp_err), 64'(re.err));
      end
    end
  end

  task automatic wait_gnt();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 400 && rsp_q.size() != 0; i++) @(negedge clk);
    check(tag, 64'(rsp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_job(input logic [NREQ-1:0] r, input int idx, input logic [WB-1:0] w,
                        input logic [NB-1:0] dv, input logic [NB-1:0] exp_n,
                        input logic exp_err, input int dly);
    found_delay = dly;
    dec_val     = dv;
    req_w[idx*WB +: WB] = w;
    gnt_q.push_back('{g: r, w: w});
    rsp_q.push_back('{id: 2'(idx), n: exp_n, err: exp_err});
    @(negedge clk);
    req = r;
    wait_gnt();
    req = '0;
    wait_rsp("job_drain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int g0, r0;
    logic [WB-1:0] saved_w;
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    for (int i = 0; i < NREQ; i++) req_w[i*WB +: WB] = 34'($urandom);
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_dec_rst_n", 64'(dec_rst_n), 64'd0);
    check("rst_dec_w", 64'(dec_w), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("dec_rst_n_release", 64'(dec_rst_n), 64'd1);

    // Single job, found after 7 WAIT cycles.
    g0 = gnt_seen;
    do_job(4'b0010, 1, 34'd12345, 21'd1048575, 21'd1048575, 1'b0, 7);
    check("single_gnt_count", 64'(gnt_seen - g0), 64'd1);
    check("single_lat", 64'(last_lat), 64'd12);

    // Reset while the job sits in WAIT.
    found_delay = 200;
    req_w[2*WB +: WB] = 34'h1_2345_6789;
    gnt_q.push_back('{g: 4'b0100, w: 34'h1_2345_6789});
    @(negedge clk);
    req = 4'b0100;
    wait_gnt();
    req = '0;
    repeat (3) @(negedge clk);
    check("pre_rst_state_wait", 64'(dut.state), 64'(2));
    r0 = rsp_seen;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 64'(dut.state), 64'd0);
    check("midrst_gnt", 64'(gnt), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_id", 64'(rsp_id), 64'd0);
    check("midrst_rsp_n", 64'(rsp_n), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    check("midrst_dec_rst_n", 64'(dec_rst_n), 64'd0);
    check("midrst_dec_w", 64'(dec_w), 64'd0);
    check("midrst_ptr", 64'(dut.ptr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dec_rst_n_release", 64'(dec_rst_n), 64'd1);
    repeat (30) @(negedge clk);
    check("midrst_no_rsp", 64'(rsp_seen - r0), 64'd0);

    // All requesters high for 8 jobs: rotation from index 0.
    found_delay = 1;
    dec_val = 21'h0ABCD;
    for (int i = 0; i < NREQ; i++) req_w[i*WB +: WB] = 34'(1000 + i);
    for (int j = 0; j < 8; j++) begin
      gnt_q.push_back('{g: 4'(1 << order[j]), w: 34'(1000 + order[j])});
      rsp_q.push_back('{id: 2'(order[j]), n: 21'h0ABCD, err: 1'b0});
    end
    g0 = gnt_seen;
    r0 = rsp_seen;
    @(negedge clk);
    req = 4'b1111;
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 300 && cnt < 8; i++) begin
        @(negedge clk);
        if (gnt != '0) cnt++;
      end
    end
    req = '0;
    wait_rsp("rr_drain");
    check("rr_gnt_count", 64'(gnt_seen - g0), 64'd8);
    check("rr_rsp_count", 64'(rsp_seen - r0), 64'd8);

    // Immediate found: minimum latency.
    do_job(4'b1000, 3, 34'h3_0000_0001, 21'h15555, 21'h15555, 1'b0, 0);
    check("min_lat", 64'(last_lat), 64'd5);

    // Operand changes during WAIT must not disturb the job.
    found_delay = 5;
    dec_val = 21'h0F0F0;
    saved_w = 34'h2_DEAD_BEEF;
    req_w[0 +: WB] = saved_w;
    gnt_q.push_back('{g: 4'b0001, w: saved_w});
    rsp_q.push_back('{id: 2'd0, n: 21'h0F0F0, err: 1'b0});
    @(negedge clk);
    req = 4'b0001;
    wait_gnt();
    req = '0;
    @(negedge clk);
    req_w[0 +: WB] = '0;
    repeat (2) @(negedge clk);
    check("dec_w_hold", 64'(dec_w), 64'(saved_w));
    wait_rsp("hold_drain");
    check("dec_w_hold_after", 64'(dec_w), 64'(saved_w));

`ifdef DEC_ARB_TIMEOUT_EN
    do_job(4'b0010, 1, 34'h0_0000_BEEF, 21'h01234, 21'd0, 1'b1, 100000);
    check("timeout_wait", 64'(last_wait), 64'd16);
    do_job(4'b0100, 2, 34'h0_0000_CAFE, 21'h00777, 21'h00777, 1'b0, 2);
    check("after_timeout_lat", 64'(last_lat), 64'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
